frame_buf_arbiter: RTL and testbench
====================================

FRAME_BUF_ARBITER -- requirements
Module: frame_buf_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 64, giving the 64-bit words per DDR burst command.
REQ-002 SHALL have parameter FRAME_WORDS, default 230400, giving the 64-bit words per frame (1280x720x16bpp / 64).
REQ-003 SHALL have parameter ADDR_W, default 24, giving the word-address width; the top 2 bits are the bank and the lower ADDR_W-2 bits are the offset.
REQ-004 ddr_clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 wr_req  in  1  camera write FIFO holds >= BURST_LEN words.
REQ-007 wr_frame_start  in  1  one-cycle pulse, camera vsync falling edge already in the ddr_clk domain.
REQ-008 rd_req  in  1  output (VGA/USB) read FIFO has room for >= BURST_LEN words.
REQ-009 rd_frame_start  in  1  one-cycle pulse, start of an output frame.
REQ-010 cmd_valid  out  1; cmd_ready  in  1; cmd_wr  out  1 (1 = write); cmd_addr  out  ADDR_W  burst command to the DDR port.
REQ-011 burst_done  in  1  pulse when the data phase of the accepted command completes.
REQ-012 wr_bank, rd_bank  out  2 each  current write and read frame banks.
REQ-013 frame_pub  out  1  one-cycle pulse when a completed frame is published.
REQ-014 drop_cnt  out  8  saturating count of incomplete (dropped) write frames.

Function
REQ-015 FSM states SHALL be IDLE, WR_CMD, WR_DATA, RD_CMD and RD_DATA.
REQ-016 In IDLE, an eligible request SHALL move the FSM to its CMD state next cycle, with cmd_valid=1 in that state.
- Write eligible: wr_req=1 and wr_full=0.
- Read eligible: rd_req=1 and latest_valid=1.
REQ-017 When both requests are eligible, the FSM SHALL grant the one not granted last (round-robin); last_grant SHALL reset to "read", so write wins the first tie.
REQ-018 In a CMD state, cmd_valid, cmd_wr and cmd_addr SHALL stay stable until cmd_ready=1; the FSM SHALL then enter the matching DATA state with cmd_valid=0.
REQ-019 In a DATA state, burst_done=1 SHALL advance the offset by BURST_LEN and return the FSM to IDLE, giving at least one IDLE cycle between bursts.
REQ-020 cmd_addr SHALL be {bank, offset}, with the bank taken from wr_bank or rd_bank per grant; FRAME_WORDS SHALL be <= 2^(ADDR_W-2).
REQ-021 Write offset reaching FRAME_WORDS SHALL set wr_full, and no further write bursts SHALL be granted until the next frame start.
REQ-022 Read offset reaching FRAME_WORDS SHALL wrap to 0, repeating the frame.
REQ-023 Frame starts SHALL be latched as pending and applied only in IDLE, never during a CMD or DATA state of the same direction.
REQ-024 Applied write frame start with wr_full=1:
- latest_bank <= wr_bank, latest_valid <= 1, frame_pub pulses.
- wr_bank <= wr_bank+1, or wr_bank+2 if wr_bank+1 equals rd_bank (mod 4).
REQ-025 Applied write frame start with wr_full=0 and offset > 0: bank is not published, drop_cnt increments (saturating at 255).
REQ-026 Applied write frame start with offset = 0: no publish, no drop count.
REQ-027 Every applied write frame start SHALL clear the write offset and wr_full.
REQ-028 Applied read frame start SHALL clear the read offset and set rd_bank <= latest_bank when latest_valid=1.
REQ-029 A write frame start and a read frame start applied in the same cycle SHALL compute rd_bank from the pre-update latest_bank, and the wr_bank skip SHALL use the new rd_bank.

Reset
REQ-030 rst SHALL force the following, regardless of FSM state, with an in-flight burst abandoned:
- state=IDLE, cmd_valid=0, cmd_wr=0, cmd_addr=0.
- wr_bank=0, rd_bank=3, latest_bank=0, latest_valid=0.
- offsets=0, wr_full=0, pending flags=0, frame_pub=0, drop_cnt=0, last_grant=read.

Structure
REQ-031 Package frame_buf_pkg SHALL hold the FSM state enumeration, the bank width (2) and the default BURST_LEN/FRAME_WORDS constants.
REQ-032 Bank rotation and publication (REQ-024 to REQ-029) SHALL be the sub-module frame_bank_ctrl; arbitration, FSM and offsets SHALL stay in the top level.

Verification (bench parameters BURST_LEN=4, FRAME_WORDS=16, ADDR_W=8)
REQ-033 Reset then wr_req=1, cmd_ready=1 -> cmd_valid the cycle after IDLE, cmd_wr=1, cmd_addr=0x00, then 0x04, 0x08, 0x0C; no 5th write command issued (wr_full).
REQ-034 Full frame then wr_frame_start -> frame_pub one cycle, wr_bank=1, latest_bank=0; then rd_frame_start -> rd_bank=0; reads issue addrs 0x00..0x0C, then wrap to 0x00.
REQ-035 wr_req and rd_req both held high with latest_valid=1 -> grants alternate W,R,W,R.
REQ-036 rd_bank=1, wr_bank=0, frame complete, wr_frame_start -> wr_bank=2 (skip).
REQ-037 wr_frame_start after 2 bursts -> no frame_pub, drop_cnt=1, next write addr offset 0; 256 such drops -> drop_cnt=255.
REQ-038 wr_frame_start during WR_DATA -> applied only after burst_done; rst asserted in WR_CMD -> cmd_valid=0 next cycle and all outputs at reset values.

Source files
------------

// File: rtl/frame_buf_pkg.sv
// Shared types and constants for the frame-buffer DDR arbiter.
// Holds the FSM state set, the bank width and the default burst and frame sizes.
package frame_buf_pkg;

    localparam int BANK_W          = 2;
    localparam int DEF_BURST_LEN   = 64;
    localparam int DEF_FRAME_WORDS = 230400;

    typedef enum logic [2:0] {
        IDLE,
        WR_CMD,
        WR_DATA,
        RD_CMD,
        RD_DATA
    } arb_state_t;

endpackage

// File: rtl/frame_buf_arbiter_bank.sv
// Bank rotation and frame publication for a 4-bank triple-buffered frame store.
// The writer never lands on the bank the reader is currently scanning out.
module frame_bank_ctrl
    import frame_buf_pkg::*;
(
    input  logic              ddr_clk,
    input  logic              rst,
    input  logic              apply_wr,
    input  logic              apply_rd,
    input  logic              wr_full,
    input  logic              wr_partial,
    output logic [BANK_W-1:0] wr_bank,
    output logic [BANK_W-1:0] rd_bank,
    output logic              latest_valid,
    output logic              frame_pub,
    output logic [7:0]        drop_cnt
);

    logic [BANK_W-1:0] latest_bank;
    logic [BANK_W-1:0] rd_bank_nxt;
    logic [BANK_W-1:0] wr_step;

    // The skip test uses the reader bank as it will be after this cycle, while the
    // reader itself picks up latest_bank before this cycle's publication.
    always_comb begin
        rd_bank_nxt = rd_bank;
        if (apply_rd && latest_valid) begin
            rd_bank_nxt = latest_bank;
        end
        wr_step = wr_bank + BANK_W'(1);
        if (wr_step == rd_bank_nxt) begin
            wr_step = wr_bank + BANK_W'(2);
        end
    end

    always_ff @(posedge ddr_clk) begin
        if (rst) begin
            wr_bank      <= '0;
            rd_bank      <= BANK_W'(3);
            latest_bank  <= '0;
            latest_valid <= 1'b0;
            frame_pub    <= 1'b0;
            drop_cnt     <= 8'd0;
        end else begin
            frame_pub <= 1'b0;
            rd_bank   <= rd_bank_nxt;
            if (apply_wr) begin
                if (wr_full) begin
                    latest_bank  <= wr_bank;
                    latest_valid <= 1'b1;
                    frame_pub    <= 1'b1;
                    wr_bank      <= wr_step;
                end else if (wr_partial && drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/frame_buf_arbiter.sv
// Round-robin DDR burst arbiter between the camera writer and the display reader.
// Issues one burst command at a time and tracks per-direction frame offsets.
module frame_buf_arbiter
    import frame_buf_pkg::*;
#(
    parameter int BURST_LEN   = DEF_BURST_LEN,
    parameter int FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int ADDR_W      = 24
) (
    input  logic              ddr_clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic              wr_frame_start,
    input  logic              rd_req,
    input  logic              rd_frame_start,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_wr,
    output logic [ADDR_W-1:0] cmd_addr,
    input  logic              burst_done,
    output logic [BANK_W-1:0] wr_bank,
    output logic [BANK_W-1:0] rd_bank,
    output logic              frame_pub,
    output logic [7:0]        drop_cnt
);

    localparam int OFF_W = ADDR_W - BANK_W;
    // One extra bit so a frame that exactly fills the offset space is still detected.
    localparam logic [OFF_W:0] BURST_INC = (OFF_W+1)'(BURST_LEN);
    localparam logic [OFF_W:0] FRAME_END = (OFF_W+1)'(FRAME_WORDS);

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic             last_grant_wr;
    logic             last_grant_nxt;
    logic [OFF_W-1:0] wr_off;
    logic [OFF_W-1:0] rd_off;
    logic [OFF_W:0]   wr_off_sum;
    logic [OFF_W:0]   rd_off_sum;
    logic             wr_full;
    logic             wr_pend;
    logic             rd_pend;
    logic             wr_elig;
    logic             rd_elig;
    logic             apply_wr;
    logic             apply_rd;
    logic             latest_valid;

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant_wr;
        cmd_valid      = 1'b0;
        cmd_wr         = 1'b0;
        cmd_addr       = '0;
        wr_elig        = wr_req && !wr_full;
        rd_elig        = rd_req && latest_valid;
        apply_wr       = (state == IDLE) && wr_pend;
        apply_rd       = (state == IDLE) && rd_pend;
        wr_off_sum     = {1'b0, wr_off} + BURST_INC;
        rd_off_sum     = {1'b0, rd_off} + BURST_INC;
        case (state)
            IDLE: begin
                if (wr_elig && (!rd_elig || !last_grant_wr)) begin
                    state_nxt      = WR_CMD;
                    last_grant_nxt = 1'b1;
                end else if (rd_elig) begin
                    state_nxt      = RD_CMD;
                    last_grant_nxt = 1'b0;
                end
            end
            WR_CMD: begin
                cmd_valid = 1'b1;
                cmd_wr    = 1'b1;
                cmd_addr  = {wr_bank, wr_off};
                if (cmd_ready) state_nxt = WR_DATA;
            end
            RD_CMD: begin
                cmd_valid = 1'b1;
                cmd_addr  = {rd_bank, rd_off};
                if (cmd_ready) state_nxt = RD_DATA;
            end
            WR_DATA, RD_DATA: begin
                if (burst_done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Frame starts wait here until the FSM is idle so an in-flight burst keeps its address.
    always_ff @(posedge ddr_clk) begin
        if (rst) begin
            state         <= IDLE;
            last_grant_wr <= 1'b0;
            wr_off        <= '0;
            rd_off        <= '0;
            wr_full       <= 1'b0;
            wr_pend       <= 1'b0;
            rd_pend       <= 1'b0;
        end else begin
            state         <= state_nxt;
            last_grant_wr <= last_grant_nxt;
            wr_pend       <= wr_frame_start || (wr_pend && !apply_wr);
            rd_pend       <= rd_frame_start || (rd_pend && !apply_rd);

            if (apply_wr) begin
                wr_off  <= '0;
                wr_full <= 1'b0;
            end else if (state == WR_DATA && burst_done) begin
                if (wr_off_sum >= FRAME_END) begin
                    wr_off  <= '0;
                    wr_full <= 1'b1;
                end else begin
                    wr_off <= wr_off_sum[OFF_W-1:0];
                end
            end

            if (apply_rd) begin
                rd_off <= '0;
            end else if (state == RD_DATA && burst_done) begin
                rd_off <= (rd_off_sum >= FRAME_END) ? '0 : rd_off_sum[OFF_W-1:0];
            end
        end
    end

    frame_bank_ctrl u_bank_ctrl (
        .ddr_clk      (ddr_clk),
        .rst          (rst),
        .apply_wr     (apply_wr),
        .apply_rd     (apply_rd),
        .wr_full      (wr_full),
        .wr_partial   (wr_off != '0),
        .wr_bank      (wr_bank),
        .rd_bank      (rd_bank),
        .latest_valid (latest_valid),
        .frame_pub    (frame_pub),
        .drop_cnt     (drop_cnt)
    );

endmodule

// File: tb/tb_frame_buf_arbiter.sv
// Bench for frame_buf_arbiter: directed scenarios plus a randomized run, all compared
// every cycle against a transaction-level model of the arbiter and its bank rotation.
module tb_frame_buf_arbiter;

    localparam int BL = 4;
    localparam int FW = 16;
    localparam int AW = 8;
    localparam int BANK_SPAN = 1 << (AW - 2);

    logic          ddr_clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_req = 1'b0;
    logic          wr_frame_start = 1'b0;
    logic          rd_req = 1'b0;
    logic          rd_frame_start = 1'b0;
    logic          cmd_ready = 1'b0;
    logic          burst_done = 1'b0;
    logic          cmd_valid;
    logic          cmd_wr;
    logic [AW-1:0] cmd_addr;
    logic [1:0]    wr_bank;
    logic [1:0]    rd_bank;
    logic          frame_pub;
    logic [7:0]    drop_cnt;

    int checks = 0;
    int errors = 0;

    logic          log_wr[$];
    logic [AW-1:0] log_addr[$];
    int            pub_count = 0;

    always #5 ddr_clk = ~ddr_clk;

    frame_buf_arbiter #(.BURST_LEN(BL), .FRAME_WORDS(FW), .ADDR_W(AW)) dut (
        .ddr_clk        (ddr_clk),
        .rst            (rst),
        .wr_req         (wr_req),
        .wr_frame_start (wr_frame_start),
        .rd_req         (rd_req),
        .rd_frame_start (rd_frame_start),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_wr         (cmd_wr),
        .cmd_addr       (cmd_addr),
        .burst_done     (burst_done),
        .wr_bank        (wr_bank),
        .rd_bank        (rd_bank),
        .frame_pub      (frame_pub),
        .drop_cnt       (drop_cnt)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: phase 0 = no burst owned, 1 = command offered, 2 = data moving.
    bit m_live = 0;
    int m_phase = 0;
    bit m_dir_wr = 0;
    bit m_last_wr = 0;
    int m_woff = 0;
    int m_roff = 0;
    bit m_full = 0;
    bit m_wpend = 0;
    bit m_rpend = 0;
    int m_wbank = 0;
    int m_rbank = 3;
    int m_lbank = 0;
    bit m_lvalid = 0;
    bit m_pub = 0;
    int m_drop = 0;

    always @(posedge ddr_clk) begin : model_step
        bit ap_w;
        bit ap_r;
        bit we;
        bit re;
        int new_r;
        if (rst) begin
            m_live = 1; m_phase = 0; m_dir_wr = 0; m_last_wr = 0;
            m_woff = 0; m_roff = 0; m_full = 0; m_wpend = 0; m_rpend = 0;
            m_wbank = 0; m_rbank = 3; m_lbank = 0; m_lvalid = 0; m_pub = 0; m_drop = 0;
        end else begin
            m_pub = 0;
            ap_w = (m_phase == 0) && m_wpend;
            ap_r = (m_phase == 0) && m_rpend;
            if (m_phase == 0) begin
                we = wr_req && !m_full;
                re = rd_req && m_lvalid;
                if (we && (!re || !m_last_wr)) begin
                    m_phase = 1; m_dir_wr = 1; m_last_wr = 1;
                end else if (re) begin
                    m_phase = 1; m_dir_wr = 0; m_last_wr = 0;
                end
            end else if (m_phase == 1) begin
                if (cmd_ready) m_phase = 2;
            end else if (burst_done) begin
                m_phase = 0;
                if (m_dir_wr) begin
                    m_woff += BL;
                    if (m_woff >= FW) begin m_full = 1; m_woff = 0; end
                end else begin
                    m_roff += BL;
                    if (m_roff >= FW) m_roff = 0;
                end
            end
            new_r = m_rbank;
            if (ap_r) begin
                m_roff = 0;
                if (m_lvalid) new_r = m_lbank;
            end
            if (ap_w) begin
                if (m_full) begin
                    m_lbank = m_wbank;
                    m_lvalid = 1;
                    m_pub = 1;
                    m_wbank = ((m_wbank + 1) % 4 == new_r) ? (m_wbank + 2) % 4 : (m_wbank + 1) % 4;
                end else if (m_woff != 0 && m_drop < 255) begin
                    m_drop++;
                end
                m_woff = 0;
                m_full = 0;
            end
            m_rbank = new_r;
            m_wpend = wr_frame_start || (m_wpend && !ap_w);
            m_rpend = rd_frame_start || (m_rpend && !ap_r);
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    initial begin
        forever begin
            @(negedge ddr_clk);
            if (m_live) begin
                checkOutput("cmd_valid", cmd_valid, m_phase == 1);
                if (m_phase == 1) begin
                    checkOutput("cmd_wr", cmd_wr, m_dir_wr);
                    checkOutput("cmd_addr", cmd_addr,
                                m_dir_wr ? m_wbank * BANK_SPAN + m_woff : m_rbank * BANK_SPAN + m_roff);
                end
                checkOutput("wr_bank", wr_bank, m_wbank);
                checkOutput("rd_bank", rd_bank, m_rbank);
                checkOutput("frame_pub", frame_pub, m_pub);
                checkOutput("drop_cnt", drop_cnt, m_drop);
            end
        end
    end

    always @(posedge ddr_clk) begin
        if (!rst && cmd_valid && cmd_ready) begin
            log_wr.push_back(cmd_wr);
            log_addr.push_back(cmd_addr);
        end
        if (frame_pub) pub_count++;
    end

    // DDR port stand-in: finishes each accepted burst after 0-3 idle cycles.
    initial begin
        bit active;
        int wait_n;
        active = 0;
        wait_n = 0;
        forever begin
            @(posedge ddr_clk);
            if (rst) begin
                active = 0;
            end else if (cmd_valid && cmd_ready) begin
                active = 1;
                wait_n = $urandom_range(0, 3);
            end
            @(negedge ddr_clk);
            burst_done = 1'b0;
            if (active) begin
                if (wait_n == 0) begin
                    burst_done = 1'b1;
                    active = 0;
                end else begin
                    wait_n--;
                end
            end
        end
    end

    task automatic applyStimulus(input logic w, input logic r, input logic wf, input logic rf, input logic rdy);
        @(negedge ddr_clk);
        wr_req = w;
        rd_req = r;
        wr_frame_start = wf;
        rd_frame_start = rf;
        cmd_ready = rdy;
    endtask

    task automatic pulseStart(input bit is_wr);
        applyStimulus(wr_req, rd_req, is_wr, !is_wr, cmd_ready);
        applyStimulus(wr_req, rd_req, 1'b0, 1'b0, cmd_ready);
    endtask

    task automatic waitCmds(input int n, input string name);
        int target;
        target = log_addr.size() + n;
        for (int t = 0; t < 200 && log_addr.size() < target; t++) @(negedge ddr_clk);
        checkOutput(name, log_addr.size() >= target, 1);
    endtask

    task automatic waitQuiet();
        int quiet;
        int last;
        quiet = 0;
        last = log_addr.size();
        for (int t = 0; t < 400 && quiet < 8; t++) begin
            @(negedge ddr_clk);
            if (log_addr.size() == last) quiet++;
            else begin quiet = 0; last = log_addr.size(); end
        end
        checkOutput("bus quiet", quiet >= 8, 1);
    endtask

    task automatic fillFrame();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        waitQuiet();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int base;
        int pub_base;
        int exp_rd[5];
        int t;
        exp_rd = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h00};

        repeat (3) @(negedge ddr_clk);
        checkOutput("reset cmd_valid", cmd_valid, 0);
        checkOutput("reset cmd_addr", cmd_addr, 0);
        checkOutput("reset wr_bank", wr_bank, 0);
        checkOutput("reset rd_bank", rd_bank, 3);
        checkOutput("reset drop_cnt", drop_cnt, 0);

        // First write frame into bank 0; the fifth burst must not be granted.
        @(negedge ddr_clk);
        rst = 1'b0;
        wr_req = 1'b1;
        cmd_ready = 1'b1;
        @(negedge ddr_clk);
        checkOutput("first cmd_valid", cmd_valid, 1);
        checkOutput("first cmd_wr", cmd_wr, 1);
        checkOutput("first cmd_addr", cmd_addr, 8'h00);
        waitCmds(4, "four writes issued");
        waitQuiet();
        checkOutput("write cmd count", log_addr.size(), 4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            checkOutput("write seq addr", log_addr[i], 4 * i);
            checkOutput("write seq dir", log_wr[i], 1);
        end

        // Publish bank 0, hand it to the reader, and read it twice round.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        pub_base = pub_count;
        pulseStart(1'b1);
        repeat (3) @(negedge ddr_clk);
        checkOutput("publish count", pub_count - pub_base, 1);
        checkOutput("wr_bank after publish", wr_bank, 1);
        pulseStart(1'b0);
        repeat (3) @(negedge ddr_clk);
        checkOutput("rd_bank after rd start", rd_bank, 0);
        base = log_addr.size();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        waitCmds(5, "five reads issued");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        waitQuiet();
        for (int i = 0; i < 5 && base + i < log_addr.size(); i++) begin
            checkOutput("read seq addr", log_addr[base + i], exp_rd[i]);
            checkOutput("read seq dir", log_wr[base + i], 0);
        end

        // Both sides requesting: grants alternate starting with write.
        base = log_addr.size();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        waitCmds(4, "four arbitrated cmds");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        waitQuiet();
        for (int i = 0; i < 4 && base + i < log_addr.size(); i++) begin
            checkOutput("round robin dir", log_wr[base + i], (i % 2) == 0);
        end

        // Rotate banks until wr_bank=0, rd_bank=1, then the next publish must skip bank 1.
        fillFrame();
        pulseStart(1'b1);
        repeat (3) @(negedge ddr_clk);
        checkOutput("wr_bank rotate 2", wr_bank, 2);
        pulseStart(1'b0);
        repeat (3) @(negedge ddr_clk);
        checkOutput("rd_bank follows latest", rd_bank, 1);
        fillFrame();
        pulseStart(1'b1);
        repeat (3) @(negedge ddr_clk);
        checkOutput("wr_bank rotate 3", wr_bank, 3);
        fillFrame();
        pulseStart(1'b1);
        repeat (3) @(negedge ddr_clk);
        checkOutput("wr_bank rotate 0", wr_bank, 0);
        fillFrame();
        pulseStart(1'b1);
        repeat (3) @(negedge ddr_clk);
        checkOutput("wr_bank skip", wr_bank, 2);
        checkOutput("rd_bank held", rd_bank, 1);

        // Partial frames are dropped, counted, and restart at offset 0.
        base = log_addr.size();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        waitCmds(2, "two partial writes");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        waitQuiet();
        checkOutput("partial write count", log_addr.size() - base, 2);
        pub_base = pub_count;
        pulseStart(1'b1);
        repeat (2) @(negedge ddr_clk);
        checkOutput("drop_cnt first", drop_cnt, 1);
        checkOutput("no publish on drop", pub_count - pub_base, 0);
        base = log_addr.size();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        waitCmds(1, "write after drop");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        waitQuiet();
        if (log_addr.size() > base) checkOutput("addr after drop", log_addr[base], 8'h80);
        for (int i = 0; i < 256; i++) begin
            pulseStart(1'b1);
            repeat (2) @(negedge ddr_clk);
            if (i == 198) checkOutput("drop_cnt counting", drop_cnt, 200);
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            waitCmds(1, "drop loop write");
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            waitQuiet();
        end
        checkOutput("drop_cnt saturated", drop_cnt, 255);

        // Frame start arriving during a write data phase waits for burst_done.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        base = log_addr.size();
        for (t = 0; t < 100 && log_addr.size() <= base; t++) @(negedge ddr_clk);
        checkOutput("write accepted", log_addr.size() > base, 1);
        wr_frame_start = 1'b1;
        @(negedge ddr_clk);
        wr_frame_start = 1'b0;
        if (log_addr.size() > base) checkOutput("in-flight addr", log_addr[base], 8'h84);
        waitCmds(1, "write after deferred start");
        if (log_addr.size() > base + 1) checkOutput("addr after deferred start", log_addr[base + 1], 8'h80);

        // Reset while a write command is being offered.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (t = 0; t < 30 && cmd_valid !== 1'b1; t++) @(negedge ddr_clk);
        checkOutput("stalled cmd offered", cmd_valid, 1);
        rst = 1'b1;
        @(negedge ddr_clk);
        checkOutput("rst cmd_valid", cmd_valid, 0);
        checkOutput("rst cmd_wr", cmd_wr, 0);
        checkOutput("rst cmd_addr", cmd_addr, 0);
        checkOutput("rst wr_bank", wr_bank, 0);
        checkOutput("rst rd_bank", rd_bank, 3);
        checkOutput("rst drop_cnt", drop_cnt, 0);
        checkOutput("rst frame_pub", frame_pub, 0);

        // Randomized traffic, frame starts at arbitrary points, stalling command port.
        @(negedge ddr_clk);
        rst = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6,
                          $urandom_range(0, 39) == 0, $urandom_range(0, 49) == 0,
                          $urandom_range(0, 9) < 7);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (20) @(negedge ddr_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
